mux4_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-input resource port among 4 requesters.
- Drives the 2-bit select of the shared 4:1 datapath mux, plus a one-hot grant back to the requesters.
- Holds each grant until the resource signals transaction completion, so the mux select never changes mid-transaction.
- Sits between pipeline/memory requesters and the shared port mux in the MIPS datapath.

---
 rtl/mux4_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux4_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_port_arbiter
// Purpose  : Round-robin arbiter sharing one 4-input resource port among four
//            requesters. Drives the 2-bit select of the shared 4:1 datapath
//            mux and a one-hot grant; a grant is held until the resource
//            reports completion (done) or the requester drops its request.
// Options  : ARB_TIMEOUT_EN - when defined, a grant held TIMEOUT_CYCLES cycles
//            without done is forcibly released and timeout_err pulses for the
//            release cycle. When undefined no hold counter exists and
//            timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] sel_nxt;
  logic       busy_nxt;
  logic [1:0] last_ptr;
  logic [1:0] last_ptr_nxt;
  logic [1:0] winner;
  logic       found;
  logic       release_now;

  // The hold counter must be able to represent TIMEOUT_CYCLES-1.
  generate
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
      $error("mux4_port_arbiter: CNT_W too small for TIMEOUT_CYCLES");
    end
  endgenerate

  // Rotating priority scan: start one past the last served requester.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[last_ptr + 2'(i)]) begin
        winner = last_ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_hit;

  assign timeout_hit = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign release_now = (state == GRANT) && (done || !req[sel] || timeout_hit);

  // Hold counter runs only while a grant is held; the error pulse marks a
  // release caused purely by the timeout (done or abandon take precedence).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= release_now && timeout_hit && !done && req[sel];
      if (state == GRANT && !release_now) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign release_now = (state == GRANT) && (done || !req[sel]);
  assign timeout_err = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      last_ptr <= 2'd3;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      last_ptr <= last_ptr_nxt;
    end
  end

  // Next-state and next-output logic; sel only moves when a new grant issues.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    sel_nxt      = sel;
    busy_nxt     = busy;
    last_ptr_nxt = last_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = 4'b0001 << winner;
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_nxt    = 4'b0000;
          busy_nxt     = 1'b0;
          last_ptr_nxt = sel;
          state_nxt    = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_port_arbiter
// Purpose  : Self-checking bench for mux4_port_arbiter. A cycle model pushes
//            the expected registered outputs into a queue at every rising
//            edge; they are popped and compared on the following falling edge.
//            Directed checks cover the reset, rotation, abandon, mid-grant
//            reset and timeout scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_port_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       e;
  } exp_t;

  exp_t exp_q[$];

  mux4_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: computes what the outputs must be after each edge.
  int         m_state = 0;
  logic [1:0] m_ptr   = 2'd3;
  int         m_cnt   = 0;
  exp_t       m_out   = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_ptr = 2'd3; m_cnt = 0; m_out = '0;
    end else begin
      case (m_state)
        0: begin
          m_out.e = 1'b0;
          if (req != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
              int idx;
              idx = (int'(m_ptr) + k) % 4;
              if (req[idx] && m_state == 0) begin
                m_out.g = 4'(1 << idx);
                m_out.s = 2'(idx);
                m_out.b = 1'b1;
                m_state = 1;
                m_cnt   = 0;
              end
            end
          end
        end
        1: begin
          logic ab, tmo;
          ab  = !req[m_out.s];
`ifdef ARB_TIMEOUT_EN
          tmo = (m_cnt == TO - 1);
`else
          tmo = 1'b0;
`endif
          if (done || ab || tmo) begin
            m_out.e = tmo && !done && !ab;
            m_out.g = 4'b0;
            m_out.b = 1'b0;
            m_ptr   = m_out.s;
            m_cnt   = 0;
            m_state = 2;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          m_out.e = 1'b0;
          m_state = 0;
        end
      endcase
    end
    exp_q.push_back(m_out);
  end

  // Scoreboard: compare every cycle against the model.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_grant", 32'(grant), 32'(e.g));
      check("sb_sel", 32'(sel), 32'(e.s));
      check("sb_busy", 32'(busy), 32'(e.b));
      check("sb_terr", 32'(timeout_err), 32'(e.e));
    end
  end

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0; req = r; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int n = 0;
    while (grant == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait_bound", 32'(n < 100), 32'd1);
    g = grant;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] seq [5];
    int held;
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;

    // Reset with all requests active.
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    wait_grant(g);
    check("first_grant", 32'(g), 32'h1);
    pulse_done();
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Single request, done three cycles later, one RELEASE with sel held.
    do_reset(4'b0000);
    req = 4'b0100;
    @(negedge clk);
    check("single_grant", 32'(grant), 32'h4);
    check("single_sel", 32'(sel), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    pulse_done();
    check("single_rel_grant", 32'(grant), 32'h0);
    check("single_rel_sel", 32'(sel), 32'd2);
    check("single_rel_busy", 32'(busy), 32'd0);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Round-robin with all requesters active.
    do_reset(4'b0000);
    req = 4'b1111;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      check("rr_grant", 32'(g), 32'(seq[i]));
      @(negedge clk);
      pulse_done();
    end
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Rotation after serving req[1], then abandon by req[3].
    do_reset(4'b0000);
    req = 4'b0010;
    wait_grant(g);
    check("rot_first", 32'(g), 32'h2);
    pulse_done();
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b1010;
    wait_grant(g);
    check("rot_pri3", 32'(g), 32'h8);
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("abandon_grant", 32'(grant), 32'h0);
    check("abandon_terr", 32'(timeout_err), 32'h0);
    wait_grant(g);
    check("rot_then1", 32'(g), 32'h2);
    pulse_done();
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a grant restores the pointer.
    do_reset(4'b0000);
    req = 4'b0100;
    wait_grant(g);
    check("midrst_pre", 32'(g), 32'h4);
    rst_n = 1'b0; req = 4'b0110;
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    wait_grant(g);
    check("midrst_winner", 32'(g), 32'h2);
    pulse_done();
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Grant held without done.
    do_reset(4'b0000);
    req = 4'b0001;
    wait_grant(g);
    held = 1;
    while (grant != 4'b0 && held < 60) begin
      @(negedge clk);
      if (grant != 4'b0) held++;
    end
`ifdef ARB_TIMEOUT_EN
    check("tmo_held", 32'(held), 32'(TO));
    check("tmo_err_pulse", 32'(timeout_err), 32'd1);
    req = 4'b0;
    @(negedge clk);
    check("tmo_err_clear", 32'(timeout_err), 32'd0);
`else
    check("hold_forever", 32'(held >= 50), 32'd1);
    check("hold_no_err", 32'(timeout_err), 32'd0);
    pulse_done();
    req = 4'b0;
`endif
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
